// File: rtl/proc_burst_master_if.sv
// Signal bundle between the CPU, the burst master and the multiplexed main bus.
// master: the burst master's view; slave: the CPU/memory side.
interface proc_burst_master_if #(
  parameter int DATA_W    = 16,
  parameter int PAGE_W    = 4,
  parameter int OFFS_W    = 12,
  parameter int MAX_BURST = 8
);
  localparam int ADDR_W = PAGE_W + OFFS_W;
  localparam int LEN_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic              cpu_req;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [LEN_W-1:0]  cpu_len;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_wdata_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_busy;
  logic              cpu_done;
  logic              cpu_err;
  logic [DATA_W-1:0] bus_ad_out;
  logic              bus_ad_oe;
  logic              bus_as;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_ad_in;
  logic              bus_rdy;

  modport master (
    input  cpu_req, cpu_rw, cpu_addr, cpu_len, cpu_wdata, bus_ad_in, bus_rdy,
    output cpu_wdata_ack, cpu_rdata, cpu_rvalid, cpu_busy, cpu_done, cpu_err,
           bus_ad_out, bus_ad_oe, bus_as, bus_rw
  );

  modport slave (
    output cpu_req, cpu_rw, cpu_addr, cpu_len, cpu_wdata, bus_ad_in, bus_rdy,
    input  cpu_wdata_ack, cpu_rdata, cpu_rvalid, cpu_busy, cpu_done, cpu_err,
           bus_ad_out, bus_ad_oe, bus_as, bus_rw
  );
endinterface

// File: rtl/proc_burst_master.sv
// Burst master: CPU req/busy handshake to a multiplexed address/data bus with page re-addressing.
// Define PROC_BURST_TIMEOUT_EN to abort requests after TIMEOUT_CYC consecutive wait states.
module proc_burst_master #(
  parameter int DATA_W      = 16,
  parameter int PAGE_W      = 4,
  parameter int OFFS_W      = 12,
  parameter int MAX_BURST   = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                 i_clk,
  input logic                 i_reset,
  proc_burst_master_if.master bif
);
  localparam int ADDR_W = PAGE_W + OFFS_W;
  localparam int LEN_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_RDATA, S_TURN} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [LEN_W:0]    r_remain;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;

  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_data_st, w_beat, w_last, w_wrap, w_abort;

  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_wrap     = (w_addr_inc[OFFS_W-1:0] == '0);
  assign w_last     = (r_remain == (LEN_W+1)'(1));
  assign w_data_st  = (r_state == S_WDATA) || (r_state == S_RDATA);
  assign w_beat     = w_data_st && bif.bus_rdy;

`ifdef PROC_BURST_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] r_wait;
  logic              r_abort;

  assign w_abort = w_data_st && !bif.bus_rdy && (r_wait == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wait  <= '0;
      r_abort <= 1'b0;
    end else begin
      // ADDR always precedes a data state, so clearing there covers data-state entry
      if (r_state == S_ADDR || w_beat)
        r_wait <= '0;
      else if (w_data_st)
        r_wait <= r_wait + WAIT_W'(1);
      if (w_abort)
        r_abort <= 1'b1;
      else if (r_state == S_TURN)
        r_abort <= 1'b0;
    end
  end

  assign bif.cpu_err = r_abort && (r_state == S_TURN);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYC != 0);
  assign w_abort      = 1'b0;
  assign bif.cpu_err  = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_rw     <= 1'b0;
      r_remain <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= w_beat && (r_state == S_RDATA);
      if (r_state == S_IDLE && bif.cpu_req) begin
        r_addr   <= bif.cpu_addr;
        r_rw     <= bif.cpu_rw;
        r_remain <= (LEN_W+1)'(bif.cpu_len) + (LEN_W+1)'(1);
      end else if (w_beat) begin
        r_addr   <= w_addr_inc;
        r_remain <= r_remain - (LEN_W+1)'(1);
        if (r_state == S_RDATA)
          r_rdata <= bif.bus_ad_in;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bif.cpu_req) w_next = S_ADDR;
      S_ADDR:  w_next = r_rw ? S_RDATA : S_WDATA;
      S_WDATA,
      S_RDATA: begin
        if (w_abort)
          w_next = S_TURN;
        else if (w_beat) begin
          if (w_last)
            w_next = S_TURN;
          else if (w_wrap)
            w_next = S_ADDR;   // page crossing: re-issue the address phase
        end
      end
      S_TURN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bif.bus_ad_out    = '0;
    bif.bus_ad_oe     = 1'b0;
    bif.bus_as        = 1'b0;
    bif.cpu_wdata_ack = 1'b0;
    case (r_state)
      S_ADDR: begin
        bif.bus_as     = 1'b1;
        bif.bus_ad_oe  = 1'b1;
        bif.bus_ad_out = DATA_W'(r_addr);
      end
      S_WDATA: begin
        bif.bus_ad_oe     = 1'b1;
        bif.bus_ad_out    = bif.cpu_wdata;
        bif.cpu_wdata_ack = bif.bus_rdy;
      end
      default: ;
    endcase
  end

  assign bif.cpu_busy   = (r_state != S_IDLE);
  assign bif.cpu_done   = (r_state == S_TURN);
  assign bif.bus_rw     = bif.cpu_busy && r_rw;
  assign bif.cpu_rdata  = r_rdata;
  assign bif.cpu_rvalid = r_rvalid;
endmodule

// File: doc/proc_burst_master.md
Name: proc_burst_master

Overview:
- Parametrised successor to the processor-side bus interface.
- Accepts single or burst read/write requests from the CPU over a req/busy handshake.
- Drives the multiplexed address/data main bus: address phase, then data beats paced by memory `bus_rdy`.
- Adds variable burst length, wait states, automatic page-boundary re-addressing and a turnaround cycle.

Parameters:
- DATA_W, 16, width of the multiplexed address/data bus and of CPU data.
- PAGE_W, 4, address page field width (upper address bits).
- OFFS_W, 12, in-page offset width; PAGE_W+OFFS_W must be <= DATA_W.
- MAX_BURST, 8, maximum beats per request (power of two, >= 1).
- TIMEOUT_CYC, 64, wait-state limit used only by the optional feature.

Ports:
- clk  in  1  bus clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  PAGE_W+OFFS_W  start address {page, offset}.
- cpu_len  in  clog2(MAX_BURST) (min 1)  beats minus one.
- cpu_wdata  in  DATA_W  current write beat data.
- cpu_wdata_ack  out  1  pulses when a write beat completes; CPU presents the next word the following cycle.
- cpu_rdata  out  DATA_W  captured read beat.
- cpu_rvalid  out  1  one-cycle pulse per read beat.
- cpu_busy  out  1  high from acceptance until return to IDLE.
- cpu_done  out  1  one-cycle pulse at end of request.
- cpu_err  out  1  timeout abort pulse (optional feature).
- bus_ad_out  out  DATA_W  address/data driven to the bus.
- bus_ad_oe  out  1  master drives bus_ad_out.
- bus_as  out  1  address strobe; address phase only.
- bus_rw  out  1  1 = read, 0 = write; valid while busy.
- bus_ad_in  in  DATA_W  data returned by memory.
- bus_rdy  in  1  memory completes the current data beat.

Behaviour:
- Reset values (asynchronous, immediate, including mid-burst): state IDLE; all outputs 0; counters and address register 0; no partial beat is completed or reported.
- States: IDLE, ADDR, WDATA, RDATA, TURN.
- IDLE:
  - If cpu_req=1, latch addr, rw and len; set beats remaining = cpu_len+1; busy rises next cycle; go to ADDR.
  - cpu_req outside IDLE is ignored.
- ADDR (exactly 1 cycle):
  - as=1, oe=1, ad_out = zero-extended current address, rw = latched rw.
  - Next state is WDATA (write) or RDATA (read).
- WDATA:
  - oe=1, ad_out=cpu_wdata, as=0.
  - Each cycle with bus_rdy=1 completes a beat: wdata_ack pulses, address increments, remaining decrements.
  - With bus_rdy=0, the beat is held with no limit (unless the optional feature is enabled).
- RDATA:
  - oe=0.
  - On bus_rdy=1: rdata <= bus_ad_in, rvalid pulses the next cycle, address increments, remaining decrements.
- Beat completion routing:
  - Last beat (remaining 1 -> 0): go to TURN.
  - Beats remain and the incremented offset wrapped to 0 (page crossing): go to ADDR with the new address {page+1, 0}.
  - Page field wraps modulo 2^PAGE_W, so address all-ones increments to 0.
  - Otherwise stay in the data state.
- TURN (1 cycle): oe=0, as=0, cpu_done=1; busy deasserts when entering IDLE. A cpu_req present during TURN is not accepted; the first accept is in IDLE.
- Latency:
  - Single write with bus_rdy tied high: req -> ADDR (+1) -> data (+2) -> TURN (+3) -> IDLE (+4).
  - Minimum request-to-request spacing is 4 cycles for 1 beat and 3+N for N beats with no page crossing; each crossing adds 1 cycle.
- bus_rdy during ADDR or TURN is ignored.
- cpu_len values above MAX_BURST-1 cannot be expressed; width fixes the maximum.

Optional Feature:
- Macro: PROC_BURST_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every completed beat and on entry to a data state, and increments each data-state cycle with bus_rdy=0.
  - On reaching TIMEOUT_CYC it aborts the request: go to TURN, cpu_err=1 together with cpu_done, no further ack/rvalid.
- Not defined: no counter; cpu_err is tied 0; waits are unbounded.

Test Plan:
- Single write, addr 0x1234, data 0xBEEF, bus_rdy=1 -> ADDR cycle with as=1, ad_out=0x1234, rw=0; then ad_out=0xBEEF with oe=1; one wdata_ack; done 2 cycles after the ADDR cycle.
- Read burst of 4 at 0x2000, memory returns 0xA0..0xA3, rdy high every other cycle -> 4 rvalid pulses carrying 0xA0..0xA3 in order; oe=0 throughout the data phase; done once.
- Write burst of 8 at 0x3FFE -> beats at 0x3FFE and 0x3FFF; second ADDR phase drives 0x4000; 6 more beats; 8 acks total; done once.
- Burst of 2 at 0xFFFF -> re-address to 0x0000 after the first beat.
- Assert reset during beat 2 of a 4-beat read -> all outputs 0 immediately; after release, a new req at 0x0100 completes normally.
- With PROC_BURST_TIMEOUT_EN and TIMEOUT_CYC=64, read with bus_rdy held 0 -> cpu_err and cpu_done pulse after 64 data-phase cycles; no rvalid; then IDLE.
